// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini SRC datapath.
// Fetch in T0-T2, per-class execute in T3-T7; memory steps stretch by MEM_LAT wait cycles.
module control_unit #(
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);
    localparam int CW = $clog2(MEM_LAT + 2);
    localparam logic [CW-1:0] LAT = CW'(MEM_LAT);
    localparam logic [4:0] OP_ADD = 5'b00011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    op;
    logic          c_ld, c_ldi, c_st, c_alu, c_imm, c_md, c_neg, c_br, c_jr, c_jal;
    logic          c_in, c_out, c_mfhi, c_mflo, c_halt, c_one, c_exec, c_addr;
    logic          t0, t1, t2, t3, t4, t5, t6, t7;
    logic          mem_step, last, done;
    logic          unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    assign c_ld   = op == 5'd0;
    assign c_ldi  = op == 5'd1;
    assign c_st   = op == 5'd2;
    assign c_alu  = op >= 5'd3 && op <= 5'd10;
    assign c_imm  = op >= 5'd11 && op <= 5'd13;
    assign c_md   = op == 5'd14 || op == 5'd15;
    assign c_neg  = op == 5'd16 || op == 5'd17;
    assign c_br   = op == 5'd18;
    assign c_jr   = op == 5'd19;
    assign c_jal  = op == 5'd20;
    assign c_in   = op == 5'd21;
    assign c_out  = op == 5'd22;
    assign c_mfhi = op == 5'd23;
    assign c_mflo = op == 5'd24;
    assign c_halt = op == 5'd26;
    assign c_one  = c_jr || c_in || c_out || c_mfhi || c_mflo;
    assign c_exec = op <= 5'd24;
    assign c_addr = c_ldi || c_ld || c_st;

    assign t0 = state_q == S_T0;
    assign t1 = state_q == S_T1;
    assign t2 = state_q == S_T2;
    assign t3 = state_q == S_T3;
    assign t4 = state_q == S_T4;
    assign t5 = state_q == S_T5;
    assign t6 = state_q == S_T6;
    assign t7 = state_q == S_T7;

    // Memory steps hold their strobes until the wait counter reaches MEM_LAT.
    assign mem_step = t1 || (t6 && c_ld) || (t7 && c_st);
    assign last     = cnt_q == LAT;
    assign done     = !mem_step || last;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = c_halt ? S_HALT : c_exec ? S_T3 : S_T0;
            S_T3:    state_d = c_one ? S_T0 : S_T4;
            S_T4:    state_d = (c_neg || c_jal) ? S_T0 : S_T5;
            S_T5:    state_d = (c_alu || c_imm || c_ldi) ? S_T0 : S_T6;
            S_T6:    state_d = (c_ld || c_st) ? S_T7 : S_T0;
            S_T7:    state_d = S_T0;
            default: state_d = S_HALT;
        endcase
        if (!done) begin
            state_d = state_q;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    assign Gra = (t3 && (c_md || c_br || c_one)) || (t4 && (c_neg || c_jal))
              || (t5 && (c_alu || c_imm || c_ldi)) || (t6 && c_st) || (t7 && c_ld);
    assign Grb = (t3 && (c_alu || c_imm || c_addr || c_neg || c_jal)) || (t4 && c_md);
    assign Grc = t4 && c_alu;
    assign Rin = (t3 && (c_jal || c_in || c_mfhi || c_mflo)) || (t4 && c_neg)
              || (t5 && (c_alu || c_imm || c_ldi)) || (t7 && c_ld);
    assign Rout = (t3 && (c_alu || c_imm || c_md || c_neg || c_br || c_jr || c_out))
               || (t4 && (c_alu || c_md || c_jal)) || (t6 && c_st);
    assign BAout = t3 && c_addr;

    assign PCout    = t0 || (t3 && c_jal) || (t4 && c_br);
    assign PCin     = t1 || (t3 && c_jr) || (t4 && c_jal) || (t6 && c_br && CON);
    assign IncPC    = t0;
    assign MARin    = t0 || (t5 && (c_ld || c_st));
    assign MDRin    = (t1 && last) || (t6 && c_ld && last) || (t6 && c_st);
    assign MDRout   = t2 || (t7 && c_ld);
    assign IRin     = t2;
    assign Yin      = (t3 && (c_alu || c_imm || c_addr || c_md)) || (t4 && c_br);
    assign Zin      = t0 || (t3 && c_neg) || (t4 && (c_alu || c_imm || c_addr || c_md)) || (t5 && c_br);
    assign Zhighout = t6 && c_md;
    assign Zlowout  = t1 || (t4 && c_neg) || (t5 && (c_alu || c_imm || c_addr || c_md)) || (t6 && c_br);
    assign HIin     = t6 && c_md;
    assign HIout    = t3 && c_mfhi;
    assign LOin     = t5 && c_md;
    assign LOout    = t3 && c_mflo;
    assign Cout     = (t4 && (c_imm || c_addr)) || (t5 && c_br);

    assign CONin     = t3 && c_br;
    assign InPortout = t3 && c_in;
    assign OutPortin = t3 && c_out;
    assign Read      = t1 || (t6 && c_ld);
    assign Write     = t7 && c_st;

    // PC increment, effective address and branch target all use ADD.
    assign alu_op = !Zin ? 5'd0 : (t0 || (t4 && c_addr) || (t5 && c_br)) ? OP_ADD : op;
    assign Run    = state_q != S_HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random and directed instructions on MEM_LAT=0 and MEM_LAT=2 instances,
// compared cycle by cycle with a per-instruction microstep model.
module tb_control_unit;
    localparam int GRA = 0, GRB = 1, GRC = 2, RIN = 3, ROUT = 4, BAOUT = 5;
    localparam int PCOUT = 6, PCIN = 7, INCPC = 8, MARIN = 9, MDRIN = 10, MDROUT = 11;
    localparam int IRIN = 12, YIN = 13, ZIN = 14, ZHI = 15, ZLO = 16, HIIN = 17;
    localparam int HIOUT = 18, LOIN = 19, LOOUT = 20, COUT = 21, CONIN = 22;
    localparam int INP = 23, OUTP = 24, READ = 25, WRITE = 26, RUN = 32;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        CON = 1'b0;
    logic [31:0] IR = 32'd0;
    logic [32:0] ov [2];
    logic [32:0] mq[$], exp_q0[$], exp_q1[$];
    int          lat_m;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        control_unit #(.MEM_LAT(2 * g)) u_dut (
            .clk(clk), .clr_n(clr_n), .IR(IR), .CON(CON),
            .Gra(ov[g][GRA]), .Grb(ov[g][GRB]), .Grc(ov[g][GRC]),
            .Rin(ov[g][RIN]), .Rout(ov[g][ROUT]), .BAout(ov[g][BAOUT]),
            .PCout(ov[g][PCOUT]), .PCin(ov[g][PCIN]), .IncPC(ov[g][INCPC]),
            .MARin(ov[g][MARIN]), .MDRin(ov[g][MDRIN]), .MDRout(ov[g][MDROUT]),
            .IRin(ov[g][IRIN]), .Yin(ov[g][YIN]), .Zin(ov[g][ZIN]),
            .Zhighout(ov[g][ZHI]), .Zlowout(ov[g][ZLO]), .HIin(ov[g][HIIN]),
            .HIout(ov[g][HIOUT]), .LOin(ov[g][LOIN]), .LOout(ov[g][LOOUT]),
            .Cout(ov[g][COUT]), .CONin(ov[g][CONIN]), .InPortout(ov[g][INP]),
            .OutPortin(ov[g][OUTP]), .Read(ov[g][READ]), .Write(ov[g][WRITE]),
            .alu_op(ov[g][31:27]), .Run(ov[g][RUN])
        );
    end

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] b(input int i);
        return 33'd1 << i;
    endfunction

    function automatic logic [32:0] alu(input logic [4:0] o);
        return {1'b0, o, 27'd0};
    endfunction

    function automatic logic [32:0] fetch0();
        return b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN) | alu(5'd3) | b(RUN);
    endfunction

    // A memory step repeats lat_m+1 times; MDRin appears only in the final repetition.
    task automatic step(input logic [32:0] v, input bit mem = 1'b0);
        for (int i = 0; i <= (mem ? lat_m : 0); i++)
            mq.push_back(((!mem || i == lat_m) ? v : (v & ~b(MDRIN))) | b(RUN));
    endtask

    task automatic model(input logic [4:0] o, input logic c, input int lat);
        logic [32:0] ad;
        ad    = alu(5'd3);
        lat_m = lat;
        mq    = {};
        step(b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN) | ad);
        step(b(ZLO) | b(PCIN) | b(READ) | b(MDRIN), 1'b1);
        step(b(MDROUT) | b(IRIN));
        if (o >= 5'd3 && o <= 5'd13) begin
            step(b(GRB) | b(ROUT) | b(YIN));
            step((o <= 5'd10 ? (b(GRC) | b(ROUT)) : b(COUT)) | b(ZIN) | alu(o));
            step(b(ZLO) | b(GRA) | b(RIN));
        end else if (o <= 5'd2) begin
            step(b(GRB) | b(BAOUT) | b(YIN));
            step(b(COUT) | b(ZIN) | ad);
            if (o == 5'd1) step(b(ZLO) | b(GRA) | b(RIN));
            else begin
                step(b(ZLO) | b(MARIN));
                if (o == 5'd0) begin
                    step(b(READ) | b(MDRIN), 1'b1);
                    step(b(MDROUT) | b(GRA) | b(RIN));
                end else begin
                    step(b(GRA) | b(ROUT) | b(MDRIN));
                    step(b(WRITE), 1'b1);
                end
            end
        end else if (o == 5'd14 || o == 5'd15) begin
            step(b(GRA) | b(ROUT) | b(YIN));
            step(b(GRB) | b(ROUT) | b(ZIN) | alu(o));
            step(b(ZLO) | b(LOIN));
            step(b(ZHI) | b(HIIN));
        end else if (o == 5'd16 || o == 5'd17) begin
            step(b(GRB) | b(ROUT) | b(ZIN) | alu(o));
            step(b(ZLO) | b(GRA) | b(RIN));
        end else if (o == 5'd18) begin
            step(b(GRA) | b(ROUT) | b(CONIN));
            step(b(PCOUT) | b(YIN));
            step(b(COUT) | b(ZIN) | ad);
            step(b(ZLO) | (c ? b(PCIN) : 33'd0));
        end else if (o == 5'd19) step(b(GRA) | b(ROUT) | b(PCIN));
        else if (o == 5'd20) begin
            step(b(PCOUT) | b(GRB) | b(RIN));
            step(b(GRA) | b(ROUT) | b(PCIN));
        end
        else if (o == 5'd21) step(b(INP) | b(GRA) | b(RIN));
        else if (o == 5'd22) step(b(GRA) | b(ROUT) | b(OUTP));
        else if (o == 5'd23) step(b(HIOUT) | b(GRA) | b(RIN));
        else if (o == 5'd24) step(b(LOOUT) | b(GRA) | b(RIN));
        if (o == 5'd26) repeat (20) mq.push_back(33'd0);
        else mq.push_back(fetch0());
    endtask

    task automatic run(input logic [31:0] ir, input logic c);
        int n;
        model(ir[31:27], c, 0);
        exp_q0 = mq;
        model(ir[31:27], c, 2);
        exp_q1 = mq;
        @(negedge clk);
        clr_n = 1'b0;
        IR    = ir;
        CON   = c;
        #1;
        check("rst_lat0", ov[0], b(RUN));
        check("rst_lat2", ov[1], b(RUN));
        @(negedge clk);
        clr_n = 1'b1;
        n = exp_q1.size() > exp_q0.size() ? exp_q1.size() : exp_q0.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < exp_q0.size())
                check($sformatf("op%0d_con%0d_lat0_cyc%0d", ir[31:27], c, k), ov[0], exp_q0[k]);
            if (k < exp_q1.size())
                check($sformatf("op%0d_con%0d_lat2_cyc%0d", ir[31:27], c, k), ov[1], exp_q1[k]);
            if (ir[31:27] == 5'd26 && k >= 5) IR = $urandom;
        end
    endtask

    task automatic st_abort();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        clr_n = 1'b0;
        IR    = {5'd2, 27'h0123456};
        CON   = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = ov[1][WRITE];
        end
        check("st_write_seen", 33'(seen), 33'd1);
        clr_n = 1'b0;
        #1;
        check("abort_lat2", ov[1], b(RUN));
        check("abort_lat0", ov[0], b(RUN));
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check("abort_t0_lat2", ov[1], fetch0());
        check("abort_t0_lat0", ov[0], fetch0());
    endtask

    initial begin
        run(32'h19908000, 1'b0);
        run({5'd0, 27'h0abcdef}, 1'b0);
        run({5'd18, 27'h0000001}, 1'b0);
        run({5'd18, 27'h0000001}, 1'b1);
        run({5'd20, 27'h1234567}, 1'b0);
        run({5'd2, 27'h7654321}, 1'b1);
        run({5'd14, 27'h0000abc}, 1'b0);
        run({5'd26, 27'h0000000}, 1'b0);
        run({5'd25, 27'h0000000}, 1'b1);
        st_abort();
        repeat (60) run($urandom, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
